// File: rtl/maxnet_iterate.sv
// Maxnet iteration engine: repeats lateral-inhibition updates on four
// activations until the downstream check reports a winner, or the limit.
module maxnet_iterate #(
  parameter int MAX_ITER = 255,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      eps,
  input  logic [31:0]      x1_in,
  input  logic [31:0]      x2_in,
  input  logic [31:0]      x3_in,
  input  logic [31:0]      x4_in,
  input  logic [31:0]      a1_in,
  input  logic [31:0]      a2_in,
  input  logic [31:0]      a3_in,
  input  logic [31:0]      a4_in,
  input  logic             done_i,
  output logic [31:0]      x1,
  output logic [31:0]      x2,
  output logic [31:0]      x3,
  output logic [31:0]      x4,
  output logic [31:0]      a1,
  output logic [31:0]      a2,
  output logic [31:0]      a3,
  output logic [31:0]      a4,
  output logic             busy,
  output logic             finished,
  output logic             timeout,
  output logic [CNT_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SUM,
    NEUR,
    COMMIT,
    FIN
  } state_t;

  state_t            state;
  logic [1:0]        k;
  logic [31:0]       eps_q;
  logic [33:0]       sum_q;
  logic [3:0][31:0]  xs;
  logic [3:0][31:0]  ns;
  logic [3:0][31:0]  as;

  logic [31:0]       xk;
  logic [33:0]       r;
  logic [49:0]       p;
  logic [31:0]       nk;

  assign x1 = xs[0];
  assign x2 = xs[1];
  assign x3 = xs[2];
  assign x4 = xs[3];
  assign a1 = as[0];
  assign a2 = as[1];
  assign a3 = as[2];
  assign a4 = as[3];

  // Shared datapath for neuron k: inhibition from the others, clamped at zero
  always_comb begin
    xk = xs[k];
    r  = sum_q - {2'b00, xk};
    p  = 50'((66'(eps_q) * 66'(r)) >> 16);
    nk = (p > {18'd0, xk}) ? 32'd0 : xk - p[31:0];
  end

  // Control FSM with registered outputs and Jacobi-style shadow update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      k          <= 2'd0;
      eps_q      <= 32'd0;
      sum_q      <= 34'd0;
      xs         <= '0;
      ns         <= '0;
      as         <= '0;
      iter_count <= '0;
      busy       <= 1'b0;
      finished   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      finished <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            xs         <= {x4_in, x3_in, x2_in, x1_in};
            as         <= {a4_in, a3_in, a2_in, a1_in};
            eps_q      <= eps;
            iter_count <= '0;
            timeout    <= 1'b0;
            busy       <= 1'b1;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (done_i) begin
            finished <= 1'b1;
            timeout  <= 1'b0;
            state    <= FIN;
          end else if (iter_count == CNT_W'(MAX_ITER)) begin
            finished <= 1'b1;
            timeout  <= 1'b1;
            state    <= FIN;
          end else begin
            state <= SUM;
          end
        end
        SUM: begin
          sum_q <= 34'(xs[0]) + 34'(xs[1])
                 + 34'(xs[2]) + 34'(xs[3]);
          k     <= 2'd0;
          state <= NEUR;
        end
        NEUR: begin
          ns[k] <= nk;
          k     <= k + 2'd1;
          if (k == 2'd3) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          xs         <= ns;
          iter_count <= iter_count + CNT_W'(1);
          state      <= CHECK;
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
